store_buffer: RTL
=================

Name: store_buffer

Overview:
- Store-side counterpart of the CPU load data filter; sits between the MEM stage and the data-memory write port.
- Takes store requests (address, rs2 data, func3) and formats them: shifts the data into its byte lanes and generates byte write strobes.
- Queues formatted stores in a small FIFO and drains them to memory over a valid/ready handshake that tolerates wait states.
- Flags misaligned or illegal stores and reports read-after-write hazards for loads that hit a still-buffered store.

Parameters:
- DEPTH, 2, number of store entries buffered; power of two, range 2 to 8.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- st_valid  in  1  store request present.
- st_ready  out  1  store request can be accepted this cycle.
- st_addr  in  32  byte address of the store.
- st_data  in  32  raw rs2 value.
- st_func3  in  3  store width: 000 SB, 001 SH, 010 SW; any other code is illegal.
- mem_valid  out  1  head entry is presented to memory.
- mem_ready  in  1  memory accepts the head entry.
- mem_addr  out  32  word-aligned address of the head entry; bits [1:0] are 00.
- mem_wdata  out  32  lane-aligned write data of the head entry.
- mem_wstrb  out  4  active-high byte strobes of the head entry.
- ld_addr  in  32  address of the load currently in the MEM stage.
- ld_conflict  out  1  the load's word matches a buffered store.
- misalign_err  out  1  one-cycle pulse for a rejected store.
- drained  out  1  buffer is empty.

Behaviour:
- Reset values: all entries invalid, count=0, mem_valid=0, mem_addr/mem_wdata/mem_wstrb=0, misalign_err=0, drained=1, st_ready=1.
- Reset mid-operation discards all buffered stores. An in-flight head entry is dropped without waiting for mem_ready.
- st_ready = (count < DEPTH). This is a registered-count decode with no combinational path from mem_ready, so a full buffer does not accept an enqueue in the same cycle as a dequeue.
- An input handshake is a cycle with st_valid && st_ready.
- Formatting, applied at input handshake (off = st_addr[1:0]):
  - SB: wdata = st_data[7:0] placed in lane off, other lanes 0; wstrb = 1 << off.
  - SH: requires off[0]=0. wdata = st_data[15:0] in lanes off..off+1, other lanes 0; wstrb = 0011 or 1100.
  - SW: requires off=00. wdata = st_data; wstrb = 1111.
- Misaligned or illegal store (SH with off[0]=1, SW with off!=00, func3 not 000/001/010):
  - Handshake still completes and nothing is enqueued.
  - misalign_err is high for exactly the next cycle.
  - Back-to-back illegal stores produce back-to-back pulses.
- Enqueue latency: a legal store accepted in cycle N is visible at the memory port no earlier than cycle N+1 (registered FIFO). If the buffer was empty, mem_valid=1 in N+1.
- Output handshake:
  - Head is dequeued on mem_valid && mem_ready.
  - While mem_valid=1 and mem_ready=0, mem_addr/mem_wdata/mem_wstrb hold stable.
  - mem_valid never drops without a completed handshake, except on reset.
- Output port when empty: mem_valid=0 and mem_addr/mem_wdata/mem_wstrb are driven 0.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count is unchanged and order is preserved (strict FIFO).
- Pointers wrap modulo DEPTH. count saturates at neither end, because st_ready gates enqueue and mem_valid gates dequeue.
- drained = (count == 0), registered.
- ld_conflict is combinational: 1 if any valid entry has mem_addr[31:2] == ld_addr[31:2]. Strobes are not compared, so any word overlap counts. The entry being enqueued in the same cycle is not compared. The head entry counts until its dequeue edge.
- No forwarding of store data; the pipeline stalls on ld_conflict.

Test Plan:
- Reset, then SB addr=0x1003 data=0xAABBCCDD -> next cycle mem_valid=1, mem_addr=0x1000, mem_wdata=0xDD000000, mem_wstrb=1000. mem_ready=1 -> drained=1 the following cycle.
- SH addr=0x2002 data=0x12345678 with mem_ready=0 for 3 cycles -> mem_wdata=0x56780000 and wstrb=1100 held stable all 3 cycles. Exactly one dequeue when mem_ready rises.
- SW addr=0x3001, then SH addr=0x3003, then func3=011 -> three consecutive misalign_err pulses, mem_valid stays 0, drained stays 1.
- DEPTH=2, mem_ready=0, three SW stores back-to-back -> st_ready=0 after two accepts. Third store accepted only the cycle after the first dequeue, and data emerges in FIFO order.
- Buffered SW at 0x4000, ld_addr=0x4002 -> ld_conflict=1; ld_addr=0x4004 -> ld_conflict=0. After the dequeue, ld_addr=0x4002 -> ld_conflict=0.
- Two stores buffered and head stalled, assert rst for one cycle -> next cycle mem_valid=0, drained=1, st_ready=1, no stale entry emitted afterwards.

Source files
------------

// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// store_buffer_if : store request, memory write port and load-hazard bundle
// Revision 1.0
// ============================================================================
interface store_buffer_if;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_func3;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] ld_addr;
   logic        ld_conflict;
   logic        misalign_err;
   logic        drained;

   // Pipeline / memory side
   modport master (
      output st_valid, st_addr, st_data, st_func3, mem_ready, ld_addr,
      input  st_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
             ld_conflict, misalign_err, drained
   );

   // Store buffer side
   modport slave (
      input  st_valid, st_addr, st_data, st_func3, mem_ready, ld_addr,
      output st_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
             ld_conflict, misalign_err, drained
   );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// store_buffer : formats stores into byte lanes/strobes and queues them in a
//                FIFO drained to data memory; flags misaligned stores and RAW hazards
// Revision 1.0
// ============================================================================
module store_buffer #(
   parameter int DEPTH = 2
) (
   input  wire logic       clk,
   input  wire logic       rst,
   store_buffer_if.slave   bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [29:0]      ent_addr_q  [DEPTH];
   logic [29:0]      ent_addr_d  [DEPTH];
   logic [31:0]      ent_wdata_q [DEPTH];
   logic [31:0]      ent_wdata_d [DEPTH];
   logic [3:0]       ent_wstrb_q [DEPTH];
   logic [3:0]       ent_wstrb_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             misalign_err_q, misalign_err_d;
   logic             drained_q, drained_d;

   logic [1:0]       off;
   logic [31:0]      fmt_wdata;
   logic [3:0]       fmt_wstrb;
   logic             illegal;
   logic             st_fire, enq, deq, not_empty;
   logic             conflict;
   logic             unused_ld_bits;

   assign unused_ld_bits = ^bus.ld_addr[1:0];

   always_comb begin
      off       = bus.st_addr[1:0];
      fmt_wdata = '0;
      fmt_wstrb = '0;
      illegal   = 1'b0;
      case (bus.st_func3)
         3'b000: begin
            fmt_wdata = {24'b0, bus.st_data[7:0]} << {off, 3'b000};
            fmt_wstrb = 4'b0001 << off;
         end
         3'b001: begin
            illegal   = off[0];
            fmt_wdata = {16'b0, bus.st_data[15:0]} << {off, 3'b000};
            fmt_wstrb = 4'b0011 << off;
         end
         3'b010: begin
            illegal   = (off != 2'b00);
            fmt_wdata = bus.st_data;
            fmt_wstrb = 4'b1111;
         end
         default: illegal = 1'b1;
      endcase
   end

   // st_ready decodes only the registered count, so a full buffer never
   // accepts in the cycle it dequeues
   assign bus.st_ready = (count_q < CNT_W'(DEPTH));
   assign not_empty    = (count_q != '0);
   assign st_fire      = bus.st_valid && bus.st_ready;
   assign enq          = st_fire && !illegal;
   assign deq          = not_empty && bus.mem_ready;

   always_comb begin
      ent_addr_d     = ent_addr_q;
      ent_wdata_d    = ent_wdata_q;
      ent_wstrb_d    = ent_wstrb_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      misalign_err_d = st_fire && illegal;
      if (enq) begin
         ent_addr_d[wr_ptr_q]  = bus.st_addr[31:2];
         ent_wdata_d[wr_ptr_q] = fmt_wdata;
         ent_wstrb_d[wr_ptr_q] = fmt_wstrb;
         wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (deq) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      drained_d = (count_d == '0);
   end

   // Entry i is live when its distance from the head is below count
   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(PTR_W'(i) - rd_ptr_q) < count_q) &&
             (ent_addr_q[i] == bus.ld_addr[31:2])) begin
            conflict = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_q[i]  <= '0;
            ent_wdata_q[i] <= '0;
            ent_wstrb_q[i] <= '0;
         end
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         misalign_err_q <= 1'b0;
         drained_q      <= 1'b1;
      end else begin
         ent_addr_q     <= ent_addr_d;
         ent_wdata_q    <= ent_wdata_d;
         ent_wstrb_q    <= ent_wstrb_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         misalign_err_q <= misalign_err_d;
         drained_q      <= drained_d;
      end
   end

   assign bus.mem_valid    = not_empty;
   assign bus.mem_addr     = not_empty ? {ent_addr_q[rd_ptr_q], 2'b00} : 32'h0;
   assign bus.mem_wdata    = not_empty ? ent_wdata_q[rd_ptr_q] : 32'h0;
   assign bus.mem_wstrb    = not_empty ? ent_wstrb_q[rd_ptr_q] : 4'h0;
   assign bus.ld_conflict  = conflict;
   assign bus.misalign_err = misalign_err_q;
   assign bus.drained      = drained_q;
endmodule
`default_nettype wire
